divisor_iterativo: RTL and testbench
====================================

Name: divisor_iterativo

Overview:
- Sequential restoring unsigned divider. Responder side of the inicie/termino divide handshake; the stimulus generator or upstream control is the initiator.
- Captures dividendo and divisor on an accepted request and produces one quotient bit per clock.
- Holds cociente stable with termino high until the initiator releases inicie.

Parameters:
- DD_W, 32, dividend width in bits.
- DV_W, 16, divisor width in bits.
- Q_W, DD_W, quotient width. Fixed equal to DD_W, so divisor 1 never overflows.

Ports:
- reloj  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inicie  input  1  start request, level; the initiator holds it high until termino falls.
- dividendo  input  DD_W  unsigned dividend; sampled only on accept.
- divisor  input  DV_W  unsigned divisor; sampled only on accept.
- termino  output  1  high = idle/done. Low while a division is in progress.
- cociente  output  Q_W  unsigned quotient. Valid whenever termino=1 after a completed op.

Behaviour:
- Reset (sampled high on an edge):
  - state=LISTO, termino=1, cociente=0, iteration counter=0, internal registers cleared.
  - Reset dominates every other input.
  - Reset during CALC aborts the operation; no partial result is visible.
- States: LISTO, CALC, FIN.
- LISTO:
  - termino=1; cociente holds its last value (0 after reset).
  - Edge with inicie=1: latch dividendo into shift register Q, latch divisor into D, clear partial remainder R (DV_W+1 bits), clear count.
  - If divisor!=0, go to CALC. If divisor==0, go to FIN.
  - termino=0 from this edge.
- CALC, each edge:
  - R' = {R[DV_W-1:0], Q[msb]}; Q shifts left.
  - If R' >= {0,D}: R = R'-D and the Q lsb shifted in is 1. Otherwise R = R' and the lsb is 0.
  - count increments. The edge that performs iteration count=Q_W-1 moves to FIN.
- FIN:
  - termino=1; cociente = Q (all ones for divide-by-zero).
  - Stays in FIN while inicie=1. Goes to LISTO on the first edge with inicie=0.
  - This prevents a level-held inicie from retriggering.
- Latency, accept at edge N:
  - termino=0 after edge N.
  - Iterations occur at edges N+1..N+Q_W.
  - termino=1 and cociente valid after edge N+Q_W, i.e. termino low for exactly Q_W cycles (32 by default).
  - Divide-by-zero: termino low for exactly 1 cycle.
- cociente changes only on entry to FIN or on reset; it never shows intermediate bits.
- Operand inputs may change freely outside the accept edge.
- inicie=1 in CALC is ignored. inicie toggling in CALC has no effect.
- Back-to-back operation: after FIN→LISTO, the next accept can occur on the following edge.

Optional Feature:
- Macro DIVISOR_RESIDUO_EN.
- Defined:
  - Adds output port residuo (DV_W), updated together with cociente on entry to FIN.
  - residuo = final R[DV_W-1:0], or 0 for divide-by-zero.
  - Reset value 0.
- Undefined:
  - No residuo port. R is still used internally; all other behaviour is identical.

Test Plan:
- Reset pulse, then inicie=0 -> termino=1, cociente=0 and state LISTO, checked before any request.
- dividendo=0x352, divisor=0x3, inicie held until termino falls -> termino low 32 cycles, then cociente=283 (0x11B) [residuo=1].
- dividendo=0xFFFFF1FD, divisor=0xFFF0 -> cociente=0x1000F [residuo=0xF2ED]. Then dividendo=1024, divisor=0x20 -> cociente=32 [residuo=0]. Both back-to-back, with no retrigger while inicie is still high in FIN.
- Idle gap of 4+ cycles, then dividendo=0xFFFFFF24, divisor=0x21 -> cociente=130150517 [residuo=15]. cociente holds the previous value (32) during the gap and throughout CALC.
- divisor=0, dividendo=0x1234 -> termino low exactly 1 cycle, cociente=0xFFFFFFFF [residuo=0].
- Accept 0x352/3, assert reset at iteration 10 -> termino=1 and cociente=0 on the next edge. A new request 0x352/3 then completes normally with 283.

Source files
------------

// File: rtl/divisor_iterativo.sv
// Restoring unsigned divider: one quotient bit per clock, result held with termino high until inicie drops.
// Latency Q_W cycles (1 for divide-by-zero); optional residuo output with DIVISOR_RESIDUO_EN.
module divisor_iterativo #(
  parameter int DD_W = 32,
  parameter int DV_W = 16,
  parameter int Q_W  = DD_W
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            inicie,
  input  logic [DD_W-1:0] dividendo,
  input  logic [DV_W-1:0] divisor,
  output logic            termino,
  output logic [Q_W-1:0]  cociente
`ifdef DIVISOR_RESIDUO_EN
  ,
  output logic [DV_W-1:0] residuo
`endif
);

  localparam int CW = $clog2(Q_W);

  typedef enum logic [1:0] {LISTO, CALC, FIN} estado_t;

  estado_t        estado, estado_sig;
  logic [Q_W-1:0] q;
  logic [DV_W-1:0] d;
  // Remainder stays below D between iterations, so DV_W bits hold it; only R' needs the extra bit.
  logic [DV_W-1:0] r;
  logic [CW-1:0]  cuenta;
  logic           espera;
  logic [DV_W:0]  r_desp;
  logic [DV_W:0]  r_sig;
  logic           bit_q;
  logic           ultima;
  logic           acepta;

  always_comb begin
    r_desp = {r, q[Q_W-1]};
    bit_q  = (r_desp >= {1'b0, d});
    r_sig  = bit_q ? (r_desp - {1'b0, d}) : r_desp;
  end

  assign ultima = (cuenta == CW'(Q_W - 1));

  always_ff @(posedge reloj) begin
    if (reset) estado <= LISTO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      LISTO:   if (inicie) estado_sig = (divisor != '0) ? CALC : FIN;
      CALC:    if (ultima) estado_sig = FIN;
      // espera keeps a divide-by-zero in FIN long enough to show one low cycle on termino.
      FIN:     if (!espera && !inicie) estado_sig = LISTO;
      default: estado_sig = LISTO;
    endcase
  end

  always_comb begin
    termino = (estado == LISTO) || ((estado == FIN) && !espera);
    acepta  = (estado == LISTO) && inicie;
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      q        <= '0;
      d        <= '0;
      r        <= '0;
      cuenta   <= '0;
      espera   <= 1'b0;
      cociente <= '0;
`ifdef DIVISOR_RESIDUO_EN
      residuo  <= '0;
`endif
    end else if (acepta) begin
      q      <= dividendo;
      d      <= divisor;
      r      <= '0;
      cuenta <= '0;
      espera <= (divisor == '0);
    end else if (estado == CALC) begin
      q      <= {q[Q_W-2:0], bit_q};
      r      <= r_sig[DV_W-1:0];
      cuenta <= cuenta + CW'(1);
      if (ultima) begin
        cociente <= {q[Q_W-2:0], bit_q};
`ifdef DIVISOR_RESIDUO_EN
        residuo  <= r_sig[DV_W-1:0];
`endif
      end
    end else if ((estado == FIN) && espera) begin
      espera   <= 1'b0;
      cociente <= '1;
`ifdef DIVISOR_RESIDUO_EN
      residuo  <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_divisor_iterativo.sv
// Randomized self-checking bench for divisor_iterativo against a transaction-level arithmetic model.
module tb_divisor_iterativo;

  logic        reloj = 1'b0;
  logic        reset;
  logic        inicie;
  logic [31:0] dividendo;
  logic [15:0] divisor;
  logic        termino;
  logic [31:0] cociente;
`ifdef DIVISOR_RESIDUO_EN
  logic [15:0] residuo;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  divisor_iterativo dut (
    .reloj     (reloj),
    .reset     (reset),
    .inicie    (inicie),
    .dividendo (dividendo),
    .divisor   (divisor),
    .termino   (termino),
    .cociente  (cociente)
`ifdef DIVISOR_RESIDUO_EN
    ,
    .residuo   (residuo)
`endif
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Model: an accepted request is busy for 32 cycles (1 for divisor 0), then publishes dd/dv
  // and keeps the result until inicie is seen low.
  int          m_busy = 0;
  bit          m_hold = 0;
  bit          started = 0;
  logic [31:0] m_coc = '0, m_pend = '0;
  logic [15:0] m_res = '0, m_rpend = '0;

  always @(posedge reloj) begin
    started = 1;
    if (reset) begin
      m_busy = 0; m_hold = 0; m_coc = '0; m_res = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_coc = m_pend; m_res = m_rpend; m_hold = 1;
      end
    end else if (m_hold) begin
      if (!inicie) m_hold = 0;
    end else if (inicie) begin
      if (divisor == 0) begin
        m_pend = 32'hFFFF_FFFF; m_rpend = '0; m_busy = 1;
      end else begin
        m_pend  = dividendo / {16'd0, divisor};
        m_rpend = 16'(dividendo % {16'd0, divisor});
        m_busy  = 32;
      end
    end
  end

  always @(negedge reloj) begin
    if (started) begin
      chk("cyc_termino", {63'd0, termino}, {63'd0, (m_busy == 0)});
      chk("cyc_cociente", {32'd0, cociente}, {32'd0, m_coc});
`ifdef DIVISOR_RESIDUO_EN
      chk("cyc_residuo", {48'd0, residuo}, {48'd0, m_res});
`endif
    end
  end

  task automatic do_op(input logic [31:0] dd, input logic [15:0] dv, input bit hold,
                       output logic [31:0] q, output int low);
    int n;
    @(posedge reloj); #1;
    dividendo = dd; divisor = dv; inicie = 1'b1;
    n = 0;
    while (termino && n < 10) begin @(posedge reloj); #1; n++; end
    low = 0;
    q   = cociente;
    if (termino) begin
      chk("accept_timeout", 64'd1, 64'd0);
      inicie = 1'b0;
      return;
    end
    if (!hold) inicie = 1'b0;
    dividendo = $urandom; divisor = 16'($urandom);
    while (!termino && low < 100) begin low++; @(posedge reloj); #1; end
    q = cociente;
    if (hold) begin
      repeat (3) @(posedge reloj);
      #1;
      chk("no_retrigger", {63'd0, termino}, 64'd1);
      inicie = 1'b0;
    end
  endtask

  logic [31:0] q;
  int          low;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inicie = 1'b0; dividendo = 32'h5A5A_5A5A; divisor = 16'h00FF;
    repeat (3) @(posedge reloj);
    #1 reset = 1'b0;
    @(posedge reloj); #1;
    chk("reset_termino", {63'd0, termino}, 64'd1);
    chk("reset_cociente", {32'd0, cociente}, 64'd0);

    do_op(32'h352, 16'h3, 0, q, low);
    chk("op1_low", low, 32);
    chk("op1_q", q, 283);
`ifdef DIVISOR_RESIDUO_EN
    chk("op1_r", residuo, 1);
`endif

    do_op(32'hFFFF_F1FD, 16'hFFF0, 1, q, low);
    chk("op2_q", q, 32'h1000F);
`ifdef DIVISOR_RESIDUO_EN
    chk("op2_r", residuo, 16'hF2ED);
`endif
    do_op(32'd1024, 16'h20, 1, q, low);
    chk("op3_q", q, 32);
`ifdef DIVISOR_RESIDUO_EN
    chk("op3_r", residuo, 0);
`endif

    repeat (5) @(posedge reloj);
    #1;
    chk("gap_hold", cociente, 32);
    do_op(32'hFFFF_FF24, 16'h21, 0, q, low);
    chk("op4_q", q, 130150517);
`ifdef DIVISOR_RESIDUO_EN
    chk("op4_r", residuo, 15);
`endif

    do_op(32'h1234, 16'h0, 0, q, low);
    chk("dz_low", low, 1);
    chk("dz_q", q, 32'hFFFF_FFFF);
`ifdef DIVISOR_RESIDUO_EN
    chk("dz_r", residuo, 0);
`endif

    // Abort a running division with reset.
    @(posedge reloj); #1;
    dividendo = 32'h352; divisor = 16'h3; inicie = 1'b1;
    @(posedge reloj); #1;
    inicie = 1'b0;
    chk("abort_busy", {63'd0, termino}, 64'd0);
    repeat (9) @(posedge reloj);
    #1 reset = 1'b1;
    @(posedge reloj); #1;
    chk("abort_termino", {63'd0, termino}, 64'd1);
    chk("abort_cociente", cociente, 0);
    reset = 1'b0;
    do_op(32'h352, 16'h3, 0, q, low);
    chk("after_abort_q", q, 283);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] dd;
      logic [15:0] dv;
      dd = $urandom;
      case ($urandom_range(0, 3))
        0:       dv = 16'h0;
        1:       dv = 16'($urandom_range(1, 15));
        default: dv = 16'($urandom);
      endcase
      do_op(dd, dv, bit'($urandom_range(0, 1)), q, low);
      chk("rnd_low", low, (dv == 0) ? 1 : 32);
      chk("rnd_q", q, (dv == 0) ? 32'hFFFF_FFFF : dd / {16'd0, dv});
      repeat ($urandom_range(0, 3)) @(posedge reloj);
    end

    @(posedge reloj); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
